// File: rtl/add_share_if.sv
// Requester/consumer bundle for the shared-adder arbiter.
// The requester side is master; the arbiter is slave.
interface add_share_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] op_a;
  logic [NREQ*WIDTH-1:0] op_b;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  res_valid;
  logic                  res_ready;
  logic [IDW-1:0]        res_id;
  logic [WIDTH-1:0]      res_sum;
  logic                  res_ovf;
  logic [7:0]            ovf_count;

  modport master (
    output req, op_a, op_b, res_ready,
    input  gnt, busy, res_valid, res_id, res_sum, res_ovf, ovf_count
  );

  modport slave (
    input  req, op_a, op_b, res_ready,
    output gnt, busy, res_valid, res_id, res_sum, res_ovf, ovf_count
  );
endinterface

// File: rtl/add_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder among NREQ requesters,
// with a valid/ready result port and a saturating overflow event counter.
module add_share_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
) (
  input logic       clk,
  input logic       rst,
  add_share_if.slave bus
);
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       cnt_q, cnt_d;

  logic             any_req;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   cand;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH:0]   sum_full;

  // Round-robin search starting just above the last winner, wrapping.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(last_q) + k) % NREQ);
      if (!any_req && bus.req[cand]) begin
        any_req = 1'b1;
        win     = cand;
      end
    end
  end

  // Winner's operand slice.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        a_sel = bus.op_a[i*WIDTH +: WIDTH];
        b_sel = bus.op_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign sum_full = {1'b0, a_q} + {1'b0, b_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    gnt_d   = '0;
    valid_d = valid_q;
    id_d    = id_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = EXEC;
          gnt_d   = NREQ'(1) << win;
          a_d     = a_sel;
          b_d     = b_sel;
          id_d    = win;
          last_d  = win;
        end
      end
      EXEC: begin
        sum_d   = sum_full[WIDTH-1:0];
        ovf_d   = sum_full[WIDTH];
        valid_d = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (bus.res_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
          if (ovf_q && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Last winner resets to NREQ-1 so requester 0 is searched first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q  <= IDW'(NREQ - 1);
      a_q     <= '0;
      b_q     <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      id_q    <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.res_valid = valid_q;
  assign bus.res_id    = id_q;
  assign bus.res_sum   = sum_q;
  assign bus.res_ovf   = ovf_q;
  assign bus.ovf_count = cnt_q;
endmodule

// File: tb/tb_add_share_arbiter.sv
// Bench for add_share_arbiter: vector table plus hand sequences for reset,
// backpressure, round-robin order and counter saturation.
module tb_add_share_arbiter;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  add_share_if #(.NREQ(4), .WIDTH(8)) bus ();

  add_share_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [3:0]  rq;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  id;
    logic [7:0]  sum;
    logic        ovf;
  } vec_t;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] sum;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[8];
  int   errors = 0;
  int   checks = 0;
  int   ovf_m  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle slot: sample outputs and drive inputs 2ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pop_check();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: result with empty queue at %0t", $time);
    end else begin
      checks--;
      e = sb.pop_front();
      chk("res_id",  32'(bus.res_id),  32'(e.id));
      chk("res_sum", 32'(bus.res_sum), 32'(e.sum));
      chk("res_ovf", 32'(bus.res_ovf), 32'(e.ovf));
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_gnt"},   32'(bus.gnt),       32'd0);
    chk({nm, "_busy"},  32'(bus.busy),      32'd0);
    chk({nm, "_valid"}, 32'(bus.res_valid), 32'd0);
    chk({nm, "_id"},    32'(bus.res_id),    32'd0);
    chk({nm, "_sum"},   32'(bus.res_sum),   32'd0);
    chk({nm, "_ovf"},   32'(bus.res_ovf),   32'd0);
    chk({nm, "_cnt"},   32'(bus.ovf_count), 32'd0);
  endtask

  // Full transaction with res_ready high, starting from IDLE.
  task automatic txn(input vec_t v);
    exp_t e;
    logic [3:0] oh;
    bus.req  = v.rq;
    bus.op_a = v.a;
    bus.op_b = v.b;
    e.id = v.id; e.sum = v.sum; e.ovf = v.ovf;
    sb.push_back(e);
    oh = 4'b0001 << v.id;
    tick();
    chk("gnt",      32'(bus.gnt),       32'(oh));
    chk("busy_gnt", 32'(bus.busy),      32'd1);
    chk("valid_e0", 32'(bus.res_valid), 32'd0);
    bus.req = 4'b0000;
    tick();
    chk("valid_e1", 32'(bus.res_valid), 32'd1);
    chk("gnt_e1",   32'(bus.gnt),       32'd0);
    pop_check();
    tick();
    if (v.ovf && ovf_m < 255) ovf_m++;
    chk("valid_e2", 32'(bus.res_valid), 32'd0);
    chk("busy_e2",  32'(bus.busy),      32'd0);
    chk("ovf_count", 32'(bus.ovf_count), 32'(ovf_m));
  endtask

  initial begin
    vec_t v;
    exp_t e;
    logic [1:0] held_id;
    logic [7:0] held_sum;
    logic       held_ovf;

    tbl[0] = '{4'b0001, 32'h0000_0012, 32'h0000_0034, 2'd0, 8'h46, 1'b0};
    tbl[1] = '{4'b0001, 32'h0000_00F0, 32'h0000_0020, 2'd0, 8'h10, 1'b1};
    tbl[2] = '{4'b0001, 32'h0000_00FF, 32'h0000_0001, 2'd0, 8'h00, 1'b1};
    tbl[3] = '{4'b0110, 32'h0080_7F00, 32'h0080_0100, 2'd1, 8'h80, 1'b0};
    tbl[4] = '{4'b0110, 32'h0080_7F00, 32'h0080_0100, 2'd2, 8'h00, 1'b1};
    tbl[5] = '{4'b1001, 32'hAA00_0001, 32'h5500_00FF, 2'd3, 8'hFF, 1'b0};
    tbl[6] = '{4'b1001, 32'hAA00_0001, 32'h5500_00FF, 2'd0, 8'h00, 1'b1};
    tbl[7] = '{4'b1000, 32'hFF00_0000, 32'hFF00_0000, 2'd3, 8'hFE, 1'b1};

    bus.req = '0; bus.op_a = '0; bus.op_b = '0; bus.res_ready = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    chk_all_zero("reset");
    rst = 1'b0;

    // Reset while a result is held in RESP.
    bus.req = 4'b0001; bus.op_a = 32'h0000_0010; bus.op_b = 32'h0000_0020;
    e.id = 2'd0; e.sum = 8'h30; e.ovf = 1'b0;
    sb.push_back(e);
    tick();
    chk("mid_gnt", 32'(bus.gnt), 32'h1);
    bus.req = 4'b0000;
    tick();
    chk("mid_valid", 32'(bus.res_valid), 32'd1);
    pop_check();
    tick();
    chk("mid_hold", 32'(bus.res_valid), 32'd1);
    #1 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    tick();
    rst = 1'b0;
    ovf_m = 0;
    bus.res_ready = 1'b1;
    v = '{4'b0010, 32'h0000_0500, 32'h0000_0600, 2'd1, 8'h0B, 1'b0};
    txn(v);

    // Vector table.
    for (int i = 0; i < 8; i++) txn(tbl[i]);

    // Backpressure: result held, no grant while requests pile up.
    bus.res_ready = 1'b0;
    bus.req = 4'b0100; bus.op_a = 32'h0033_0000; bus.op_b = 32'h0044_0000;
    e.id = 2'd2; e.sum = 8'h77; e.ovf = 1'b0;
    sb.push_back(e);
    tick();
    chk("bp_gnt", 32'(bus.gnt), 32'h4);
    bus.req = 4'b1111;
    tick();
    chk("bp_valid", 32'(bus.res_valid), 32'd1);
    held_id = bus.res_id; held_sum = bus.res_sum; held_ovf = bus.res_ovf;
    pop_check();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", 32'(bus.res_valid), 32'd1);
      chk("bp_hold_id",    32'(bus.res_id),    32'(2'd2));
      chk("bp_hold_sum",   32'(bus.res_sum),   32'h77);
      chk("bp_hold_ovf",   32'(bus.res_ovf),   32'd0);
      chk("bp_no_gnt",     32'(bus.gnt),       32'd0);
      chk("bp_busy",       32'(bus.busy),      32'd1);
    end
    if (held_id !== 2'd2 || held_sum !== 8'h77 || held_ovf !== 1'b0) begin
      checks++; errors++;
      $display("FAIL bp_capture: got id=%0d sum=%0h ovf=%0b", held_id, held_sum, held_ovf);
    end
    bus.res_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(bus.res_valid), 32'd0);
    chk("bp_release_busy",  32'(bus.busy),      32'd0);
    bus.req = 4'b0000;
    tick();
    chk("bp_after_gnt", 32'(bus.gnt), 32'd0);

    // Round-robin with all requesters asserted.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ovf_m = 0;
    chk("rr_cnt_reset", 32'(bus.ovf_count), 32'd0);
    bus.op_a = 32'h4030_2010; bus.op_b = 32'h0403_0201;
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      logic [3:0] oh;
      oh = 4'b0001 << (g % 4);
      tick();
      chk("rr_gnt", 32'(bus.gnt), 32'(oh));
      e.id = 2'(g % 4); e.sum = 8'(((g % 4) + 1) * 8'h11); e.ovf = 1'b0;
      sb.push_back(e);
      tick();
      chk("rr_valid", 32'(bus.res_valid), 32'd1);
      chk("rr_gap1",  32'(bus.gnt),       32'd0);
      pop_check();
      tick();
      chk("rr_gap2",  32'(bus.gnt),       32'd0);
      chk("rr_done",  32'(bus.res_valid), 32'd0);
    end
    bus.req = 4'b0000;

    // Saturation of the overflow counter.
    bus.op_a = 32'h0000_00FF; bus.op_b = 32'h0000_00FF;
    bus.req = 4'b0001;
    for (int n = 0; n < 260; n++) begin
      tick();
      tick();
      chk("sat_sum", 32'(bus.res_sum), 32'hFE);
      tick();
      if (ovf_m < 255) ovf_m++;
      chk("sat_cnt", 32'(bus.ovf_count), 32'(ovf_m));
    end
    bus.req = 4'b0000;
    repeat (4) tick();
    chk("sat_final", 32'(bus.ovf_count), 32'd255);
    chk("sb_empty",  32'(sb.size()),     32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
